// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_pkg
//  Description : Shared FSM state encoding and default widths for the
//                sequential restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH  = 4;
  localparam int DEFAULT_DWIDTH = DEFAULT_WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring-division iteration: shift the partial
//                remainder left, bring in the next dividend bit, and subtract
//                the divisor when it fits, producing one quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int DWIDTH = 2
) (
  input  logic [DWIDTH-1:0] i_rem,
  input  logic              i_bit,
  input  logic [DWIDTH-1:0] i_divisor,
  output logic [DWIDTH-1:0] o_rem,
  output logic              o_q_bit
);

  // The shifted remainder needs one extra bit so the compare never overflows.
  logic [DWIDTH:0] w_shifted;
  logic [DWIDTH:0] w_diff;
  logic            w_fits;

  // Shift, compare and conditionally subtract.
  always_comb begin
    w_shifted = {i_rem, i_bit};
    w_diff    = w_shifted - {1'b0, i_divisor};
    w_fits    = (w_shifted >= {1'b0, i_divisor});
    o_q_bit   = w_fits;
    // Either result is strictly below the divisor, so the top bit is always 0.
    o_rem     = w_fits ? w_diff[DWIDTH-1:0] : w_shifted[DWIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Unsigned sequential restoring divider, one quotient bit per
//                clock. Divide-by-zero short-circuits to an all-ones quotient.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DWIDTH = WIDTH / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [DWIDTH-1:0] divisor,
  output logic [WIDTH-1:0]  quotient,
  output logic [DWIDTH-1:0] remainder,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e            state_q, state_d;
  // acc holds the unconsumed dividend bits in its top and collects quotient
  // bits from the bottom; after WIDTH steps it is exactly the quotient.
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [DWIDTH-1:0] rem_q, rem_d;
  logic [DWIDTH-1:0] div_q, div_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dbz_q, dbz_d;

  logic [DWIDTH-1:0] w_step_rem;
  logic              w_step_bit;

  div_step #(
    .DWIDTH (DWIDTH)
  ) u_div_step (
    .i_rem     (rem_q),
    .i_bit     (acc_q[WIDTH-1]),
    .i_divisor (div_q),
    .o_rem     (w_step_rem),
    .o_q_bit   (w_step_bit)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            acc_d   = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            acc_d   = dividend;
            div_d   = divisor;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = {acc_q[WIDTH-2:0], w_step_bit};
        rem_d = w_step_rem;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = acc_q;
  assign remainder   = rem_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider (WIDTH=4, DWIDTH=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [1:0] divisor;
  logic [3:0] quotient;
  logic [1:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [3:0] q;
    logic [1:0] r;
    logic       z;
    int         lat;
  } exp_t;

  exp_t sb[$];

  seq_divider #(
    .WIDTH  (4),
    .DWIDTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Drive one divide (start in the current cycle), push the expected result,
  // wait for done and capture what the DUT produced. Latency is counted in
  // cycles from the cycle start was presented; -1 means done never came.
  task automatic run_op(input logic [3:0] dd, input logic [1:0] dv,
                        output int lat, output logic [3:0] q,
                        output logic [1:0] r, output logic z,
                        output logic done_next);
    exp_t e;
    int   n;
    e.q   = (dv == 2'd0) ? 4'hF : dd / {2'b00, dv};
    e.r   = (dv == 2'd0) ? 2'd0 : 2'(dd % {2'b00, dv});
    e.z   = (dv == 2'd0);
    e.lat = (dv == 2'd0) ? 1 : 5;
    sb.push_back(e);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 2'($urandom);
    n = 1;
    while (n <= 20 && !done) begin
      @(posedge clk); #1;
      n++;
    end
    lat = done ? n : -1;
    q   = quotient;
    r   = remainder;
    z   = div_by_zero;
    @(posedge clk); #1;
    done_next = done;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; dividend = 4'd9; divisor = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 9'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    else pass_cnt++;
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, done} !== 2'b00)
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int lat; logic [3:0] q; logic [1:0] r; logic z, dn; exp_t e;
    run_op(4'd15, 2'd3, lat, q, r, z, dn);
    e = sb.pop_front();
    total_cnt++;
    if ({q, r, z} !== {e.q, e.r, e.z})
      $display("FAIL basic_15_3: got q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b", q, r, z, e.q, e.r, e.z);
    else pass_cnt++;
    total_cnt++;
    if (lat !== e.lat) $display("FAIL basic_latency: got %0d, want %0d", lat, e.lat);
    else pass_cnt++;
    total_cnt++;
    if (dn !== 1'b0) $display("FAIL done_single_pulse: got done=%b after pulse, want 0", dn);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({quotient, remainder, busy} !== {e.q, e.r, 1'b0})
      $display("FAIL result_hold: got q=%0d r=%0d busy=%b, want q=%0d r=%0d busy=0",
               quotient, remainder, busy, e.q, e.r);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat; logic [3:0] q; logic [1:0] r; logic z, dn; exp_t e;
    run_op(4'd9, 2'd2, lat, q, r, z, dn);
    e = sb.pop_front();
    total_cnt++;
    if ({q, r, z, lat} !== {e.q, e.r, e.z, e.lat})
      $display("FAIL b2b_9_2: got q=%0d r=%0d z=%b lat=%0d, want q=%0d r=%0d z=%b lat=%0d",
               q, r, z, lat, e.q, e.r, e.z, e.lat);
    else pass_cnt++;
    // Started in the very first IDLE cycle after DONE.
    run_op(4'd2, 2'd3, lat, q, r, z, dn);
    e = sb.pop_front();
    total_cnt++;
    if ({q, r, z, lat} !== {e.q, e.r, e.z, e.lat})
      $display("FAIL b2b_2_3: got q=%0d r=%0d z=%b lat=%0d, want q=%0d r=%0d z=%b lat=%0d",
               q, r, z, lat, e.q, e.r, e.z, e.lat);
    else pass_cnt++;
  endtask

  task automatic test_div_by_zero;
    int lat; logic [3:0] q; logic [1:0] r; logic z, dn; exp_t e;
    run_op(4'd7, 2'd0, lat, q, r, z, dn);
    e = sb.pop_front();
    total_cnt++;
    if ({q, r, z} !== {e.q, e.r, e.z})
      $display("FAIL dbz_result: got q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b", q, r, z, e.q, e.r, e.z);
    else pass_cnt++;
    total_cnt++;
    if (lat !== e.lat) $display("FAIL dbz_latency: got %0d, want %0d", lat, e.lat);
    else pass_cnt++;
    run_op(4'd6, 2'd2, lat, q, r, z, dn);
    e = sb.pop_front();
    total_cnt++;
    if ({q, r, z, lat} !== {e.q, e.r, e.z, e.lat})
      $display("FAIL dbz_clear_6_2: got q=%0d r=%0d z=%b lat=%0d, want q=%0d r=%0d z=%b lat=%0d",
               q, r, z, lat, e.q, e.r, e.z, e.lat);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start;
    exp_t e; int n; int lat; int extra;
    e.q = 4'd4; e.r = 2'd0; e.z = 1'b0; e.lat = 5;
    sb.push_back(e);
    dividend = 4'd12; divisor = 2'd3; start = 1'b1;
    @(posedge clk); #1;                       // cycle 1
    start = 1'b0;
    @(posedge clk); #1;                       // cycle 2: busy, start ignored
    dividend = 4'd1; divisor = 2'd1; start = 1'b1;
    @(posedge clk); #1;                       // cycle 3
    start = 1'b0;
    n = 3;
    while (n <= 20 && !done) begin
      @(posedge clk); #1;
      n++;
    end
    lat = done ? n : -1;
    e = sb.pop_front();
    total_cnt++;
    if ({quotient, remainder, div_by_zero, lat} !== {e.q, e.r, e.z, e.lat})
      $display("FAIL ignore_start_12_3: got q=%0d r=%0d z=%b lat=%0d, want q=%0d r=%0d z=%b lat=%0d",
               quotient, remainder, div_by_zero, lat, e.q, e.r, e.z, e.lat);
    else pass_cnt++;
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL ignore_start_no_second_op: got %0d busy/done cycles, want 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort;
    int lat; logic [3:0] q; logic [1:0] r; logic z, dn; exp_t e; int seen;
    dividend = 4'd14; divisor = 2'd3; start = 1'b1;
    @(posedge clk); #1;                       // RUN cycle 1
    start = 1'b0;
    @(posedge clk); #1;                       // RUN cycle 2
    @(posedge clk); #1;                       // RUN cycle 3
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 9'd0)
      $display("FAIL abort_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    else pass_cnt++;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL abort_no_done: got %0d done pulses, want 0", seen);
    else pass_cnt++;
    run_op(4'd14, 2'd3, lat, q, r, z, dn);
    e = sb.pop_front();
    total_cnt++;
    if ({q, r, z, lat} !== {e.q, e.r, e.z, e.lat})
      $display("FAIL abort_rerun_14_3: got q=%0d r=%0d z=%b lat=%0d, want q=%0d r=%0d z=%b lat=%0d",
               q, r, z, lat, e.q, e.r, e.z, e.lat);
    else pass_cnt++;
  endtask

  task automatic test_sweep;
    int lat; logic [3:0] q; logic [1:0] r; logic z, dn; exp_t e;
    int recon;
    for (int dd = 0; dd < 16; dd++) begin
      for (int dv = 0; dv < 4; dv++) begin
        run_op(4'(dd), 2'(dv), lat, q, r, z, dn);
        e = sb.pop_front();
        total_cnt++;
        if ({q, r, z, lat} !== {e.q, e.r, e.z, e.lat})
          $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d z=%b lat=%0d, want q=%0d r=%0d z=%b lat=%0d",
                   dd, dv, q, r, z, lat, e.q, e.r, e.z, e.lat);
        else pass_cnt++;
        if (dv != 0) begin
          recon = int'(q) * dv + int'(r);
          total_cnt++;
          if (recon !== dd || int'(r) >= dv)
            $display("FAIL sweep_identity_%0d_%0d: got q*d+r=%0d r=%0d, want %0d with r<%0d",
                     dd, dv, recon, r, dd, dv);
          else pass_cnt++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 2'd0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_by_zero();
    test_ignore_start();
    test_reset_abort();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the dividend and quotient width in bits.
REQ-002 SHALL have parameter DWIDTH, default WIDTH/2, giving the divisor and remainder width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-006 SHALL have port dividend, input, WIDTH bits: unsigned numerator, sampled with start.
REQ-007 SHALL have port divisor, input, DWIDTH bits: unsigned denominator, sampled with start.
REQ-008 SHALL have port quotient, output, WIDTH bits: registered result.
REQ-009 SHALL have port remainder, output, DWIDTH bits: registered result.
REQ-010 SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-011 SHALL have port done, output, 1 bit: single-cycle pulse when results become valid.
REQ-012 SHALL have port div_by_zero, output, 1 bit: flags the last operation as divisor == 0.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1 and divisor!=0, latch both operands, clear the partial remainder, load an iteration counter with WIDTH, and go to RUN.
REQ-015 SHALL, in IDLE with start=1 and divisor==0, skip RUN, go to DONE, and load quotient=all ones, remainder=0 and div_by_zero=1.
REQ-016 SHALL, in each RUN cycle, perform one restoring step: shift the remainder left and bring in the dividend MSB; if the remainder >= divisor, subtract and shift in quotient bit 1, otherwise shift in 0.
REQ-017 SHALL compute the partial remainder at DWIDTH+1 bits so the compare never overflows.
REQ-018 SHALL decrement the counter each RUN cycle and go to DONE when the counter reaches 1.
REQ-019 SHALL, in DONE, drive done=1 for exactly one cycle and then return to IDLE.
REQ-020 SHALL make quotient and remainder valid in the DONE cycle and hold them until the next accepted start.
REQ-021 SHALL have latency start-edge to done of WIDTH+1 cycles for divisor!=0, and 1 cycle for divisor==0.
REQ-022 SHALL ignore start while busy=1; the operation in flight continues unchanged.
REQ-023 SHALL accept start in the first IDLE cycle after DONE, giving back-to-back throughput of one divide per WIDTH+2 cycles.
REQ-024 SHALL clear div_by_zero on the next accepted start with a nonzero divisor.
REQ-025 SHALL leave the results unaffected by operand input changes after start is accepted.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, force state=IDLE, quotient=0, remainder=0, busy=0, done=0 and div_by_zero=0.
REQ-027 SHALL give rst priority over start and over any in-flight RUN or DONE cycle; an aborted divide produces no done pulse.

Structure
REQ-028 SHALL place the FSM state typedef (IDLE/RUN/DONE) and default width constants in package seq_divider_pkg.
REQ-029 SHALL implement one restoring iteration (shift, compare, conditional subtract, quotient bit) as combinational sub-module div_step, instantiated once.

Verification
REQ-030 SHALL cover: dividend=15, divisor=3 -> quotient=5, remainder=0, done 5 cycles after start, div_by_zero=0.
REQ-031 SHALL cover: dividend=9, divisor=2 -> quotient=4, remainder=1; then dividend=2, divisor=3 back-to-back -> quotient=0, remainder=2.
REQ-032 SHALL cover: dividend=7, divisor=0 -> done 1 cycle after start, quotient=15, remainder=0, div_by_zero=1; the next divide of 6/2 -> quotient=3, div_by_zero=0.
REQ-033 SHALL cover: start with 12/3, then start with 1/1 two cycles later -> the second start is ignored and the result is quotient=4, remainder=0.
REQ-034 SHALL cover: rst asserted in the third RUN cycle of 14/3 -> next cycle IDLE, all outputs 0, no done pulse; then 14/3 -> quotient=4, remainder=2.
REQ-035 SHALL cover: an exhaustive sweep of all 16x4 operand pairs against a reference model, where quotient*divisor+remainder == dividend and remainder < divisor.
